// File: rtl/bp_table_port_arbiter.sv
// Port arbiter for the branch predictor's single-port 2-bit counter table: lookups vs. queued RMW updates.
// Optional store-to-load forwarding of the in-flight update is enabled by defining BP_ARB_FWD_EN.
module bp_table_port_arbiter #(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_ready,
    output logic             lk_rvalid,
    output logic [1:0]       lk_ctr,
    input  logic             fb_valid,
    input  logic [IDX_W-1:0] fb_idx,
    input  logic             fb_taken,
    output logic             fb_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       q_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  q_taken;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [STV_W-1:0]       starve;
    logic [1:0]             new_ctr;
    logic [1:0]             ctr_hold;
    logic [1:0]             rd_val;

    logic                   upd_want;
    logic                   upd_force;
    logic                   lk_grant;
    logic                   upd_grant;
    logic                   push;
    logic                   pop;
    logic [IDX_W-1:0]       head_idx;
    logic                   head_taken;

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'd1;
        end else begin
            if (c != 2'b00) r = c - 2'd1;
        end
        return r;
    endfunction

    assign head_idx   = q_idx[rd_ptr];
    assign head_taken = q_taken[rd_ptr];

    // Arbitration: a starved update preempts lookups, otherwise lookups take the port first.
    assign upd_want  = (state == S_RD) || (state == S_WR);
    assign upd_force = upd_want && (starve == STARVE_LIM);
    assign lk_grant  = !rst && lk_valid && !upd_force;
    assign upd_grant = !rst && upd_want && !lk_grant;

    assign fb_ready = rst || (count != CNT_FULL);
    assign push     = !rst && fb_valid && (count != CNT_FULL);
    assign pop      = upd_grant && (state == S_WR);

    assign lk_ready  = lk_grant;
    assign tbl_en    = lk_grant || upd_grant;
    assign tbl_we    = pop;
    assign tbl_addr  = lk_grant ? lk_idx : head_idx;
    assign tbl_wdata = new_ctr;

`ifdef BP_ARB_FWD_EN
    logic fwd_hit;
    assign rd_val = fwd_hit ? new_ctr : tbl_rdata;
`else
    assign rd_val = tbl_rdata;
`endif

    // Between responses the last returned counter is held on lk_ctr.
    assign lk_ctr = lk_rvalid ? rd_val : ctr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            new_ctr   <= '0;
            ctr_hold  <= 2'b01;
            lk_rvalid <= 1'b0;
`ifdef BP_ARB_FWD_EN
            fwd_hit   <= 1'b0;
`endif
        end else begin
            lk_rvalid <= lk_grant;
            if (lk_rvalid) ctr_hold <= lk_ctr;
`ifdef BP_ARB_FWD_EN
            fwd_hit <= lk_grant && ((state == S_RWAIT) || (state == S_WR)) && (lk_idx == head_idx);
`endif

            if (push) begin
                q_idx[wr_ptr]   <= fb_idx;
                q_taken[wr_ptr] <= fb_taken;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);

            if (upd_grant)                           starve <= '0;
            else if (upd_want && starve != STARVE_LIM) starve <= starve + STV_W'(1);

            case (state)
                S_IDLE:  if (count != '0) state <= S_RD;
                S_RD:    if (upd_grant) state <= S_RWAIT;
                S_RWAIT: begin
                    new_ctr <= sat_update(tbl_rdata, head_taken);
                    state   <= S_WR;
                end
                S_WR:    if (upd_grant) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_table_port_arbiter.sv
// Self-checking bench for bp_table_port_arbiter: directed scenarios plus a randomized phase,
// checked against an in-order update list and a golden counter table.
module tb_bp_table_port_arbiter;

    localparam int unsigned IDX_W      = 6;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned HEAD_BOUND = 2 * STARVE_MAX + 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       val;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             lk_rvalid;
    logic [1:0]       lk_ctr;
    logic             fb_valid;
    logic [IDX_W-1:0] fb_idx;
    logic             fb_taken;
    logic             fb_ready;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;

    always #5 clk = ~clk;

    bp_table_port_arbiter #(
        .IDX_W(IDX_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
        .lk_rvalid(lk_rvalid), .lk_ctr(lk_ctr),
        .fb_valid(fb_valid), .fb_idx(fb_idx), .fb_taken(fb_taken), .fb_ready(fb_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    // SRAM model: 1-cycle read latency, garbage on rdata when no read was issued.
    logic [1:0]       mem [64];
    logic             pl_en, pl_all;
    logic [IDX_W-1:0] pl_addr;
    logic [1:0]       pl_data;

    always @(posedge clk) begin
        if (pl_all) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'($urandom);
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (tbl_en && !tbl_we) tbl_rdata <= mem[tbl_addr];
        else                   tbl_rdata <= 2'($urandom);
        if (tbl_en && tbl_we)  mem[tbl_addr] <= tbl_wdata;
    end

    int          errors = 0;
    int          checks = 0;
    int unsigned ncyc = 0;
    int unsigned head_since = 0;
    int unsigned n_acc = 0;
    bit          armed = 0;
    bit          exp_rv = 0;
    logic [1:0]  exp_ctr, exp_alt;
    logic [1:0]  gold [64];
    wr_t         exp_wr [$];

    logic             s_en, s_we, s_lkr, s_fbr, s_rv;
    logic [IDX_W-1:0] s_addr;
    logic [1:0]       s_wdata, s_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // One clock: sample at negedge, update the model, then advance to just after the next posedge.
    task automatic cyc();
        wr_t e;
        @(negedge clk);
        ncyc++;
        s_en = tbl_en; s_we = tbl_we; s_addr = tbl_addr; s_wdata = tbl_wdata;
        s_lkr = lk_ready; s_fbr = fb_ready; s_rv = lk_rvalid; s_ctr = lk_ctr;
        if (armed) begin
            chk("lk_rvalid", lk_rvalid, exp_rv);
            if (exp_rv && lk_rvalid === 1'b1) begin
`ifdef BP_ARB_FWD_EN
                chk("lk_ctr", lk_ctr, (lk_ctr === exp_alt) ? exp_alt : exp_ctr);
`else
                chk("lk_ctr", lk_ctr, exp_ctr);
`endif
            end
            chk("fb_ready", fb_ready, rst || (exp_wr.size() < FIFO_DEPTH));
        end
        if (rst) begin
            chk("rst_tbl_en", tbl_en, 0);
            chk("rst_lk_ready", lk_ready, 0);
            chk("rst_fb_ready", fb_ready, 1);
            exp_wr.delete();
            for (int i = 0; i < 64; i++) gold[i] = mem[i];
        end else begin
            if (lk_ready) chk("lk_ready_req", lk_valid, 1);
            if (exp_wr.size() == 0) chk("lk_ready_free", lk_ready, lk_valid);
            if (tbl_en && tbl_we) begin
                chk("wr_pending", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", tbl_addr, e.idx);
                    chk("wr_data", tbl_wdata, e.val);
                    chk("head_bound", (ncyc - head_since) <= HEAD_BOUND, 1);
                    head_since = ncyc;
                end
            end
            if (fb_valid && fb_ready) begin
                if (exp_wr.size() == 0) head_since = ncyc;
                e.idx = fb_idx;
                e.val = sat(gold[fb_idx], fb_taken);
                gold[fb_idx] = e.val;
                exp_wr.push_back(e);
                n_acc++;
            end
        end
        exp_rv = lk_ready;
        if (lk_ready) begin
            exp_ctr = mem[lk_idx];
            exp_alt = (exp_wr.size() != 0 && exp_wr[0].idx == lk_idx) ? exp_wr[0].val : exp_ctr;
        end
        if (rst) armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1; lk_valid = 0; fb_valid = 0;
        cyc();
        rst = 0;
    endtask

    task automatic preload(input logic [IDX_W-1:0] a, input logic [1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        cyc();
        pl_en = 0;
        gold[a] = d;
    endtask

    task automatic push_one(input logic [IDX_W-1:0] a, input logic t);
        fb_valid = 1; fb_idx = a; fb_taken = t;
        cyc();
        fb_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned k_rd, k_wr, acc0, nw;
        logic        rd_seen, wr_seen, lkr_rd;
        logic [1:0]  wv [2];
        logic [1:0]  wdat, m24;
        int unsigned mism;

        rst = 1; lk_valid = 0; lk_idx = '0; fb_valid = 0; fb_idx = '0; fb_taken = 0;
        pl_en = 0; pl_all = 1; pl_addr = '0; pl_data = '0;
        cyc();
        pl_all = 0;
        reset_dut();

        // Reset state
        cyc();
        chk("reset_lk_rvalid", s_rv, 0);
        chk("reset_lk_ctr", s_ctr, 2'b01);
        chk("reset_fb_ready", s_fbr, 1);
        chk("reset_tbl_en", s_en, 0);

        // 1: single taken update of entry 5 (01 -> 10)
        reset_dut();
        preload(6'd5, 2'b01);
        push_one(6'd5, 1'b1);
        rd_seen = 0; wr_seen = 0; wdat = '0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (s_en && !s_we && s_addr == 6'd5 && !wr_seen) rd_seen = 1;
            if (s_en && s_we && s_addr == 6'd5) begin wr_seen = 1; wdat = s_wdata; end
        end
        chk("t1_read", rd_seen, 1);
        chk("t1_write", wr_seen, 1);
        chk("t1_wdata", wdat, 2'b10);
        chk("t1_queue_empty", exp_wr.size(), 0);

        // 2: two updates to entry 3 compose in order
        reset_dut();
        preload(6'd3, 2'b11);
        fb_valid = 1; fb_idx = 6'd3; fb_taken = 1; cyc();
        fb_taken = 0; cyc();
        fb_valid = 0;
        nw = 0;
        for (int k = 0; k < 40 && nw < 2; k++) begin
            cyc();
            if (s_en && s_we && s_addr == 6'd3) begin wv[nw] = s_wdata; nw++; end
        end
        chk("t2_nwrites", nw, 2);
        chk("t2_first", wv[0], 2'b11);
        chk("t2_second", wv[1], 2'b10);

        // 3: lookups every cycle; update must force its way in after STARVE_MAX stalls
        reset_dut();
        lk_valid = 1; lk_idx = 6'(32 + $urandom_range(0, 31));
        push_one(6'd7, 1'b0);
        k_rd = 0; lkr_rd = 1;
        for (int k = 1; k <= 40; k++) begin
            lk_idx = 6'(32 + $urandom_range(0, 31));
            cyc();
            if (s_en && !s_we && s_addr == 6'd7) begin k_rd = k; lkr_rd = s_lkr; break; end
        end
        chk("t3_rd_wait", k_rd, STARVE_MAX + 2);
        chk("t3_rd_lk_ready", lkr_rd, 0);
        k_wr = 0;
        for (int k = 1; k <= 40; k++) begin
            lk_idx = 6'(32 + $urandom_range(0, 31));
            cyc();
            if (s_en && s_we && s_addr == 6'd7) begin k_wr = k; break; end
        end
        chk("t3_wr_wait", k_wr, STARVE_MAX + 2);
        lk_valid = 0;

        // 4: five back-to-back pushes into a depth-4 queue while lookups hog the port
        reset_dut();
        preload(6'd24, 2'b10);
        m24 = 2'b10;
        acc0 = n_acc;
        lk_valid = 1;
        for (int j = 0; j < 5; j++) begin
            lk_idx = 6'(40 + $urandom_range(0, 23));
            fb_valid = 1; fb_idx = 6'(20 + j); fb_taken = 1'($urandom);
            cyc();
            if (j == 3) chk("t4_ready_4th", s_fbr, 1);
            if (j == 4) chk("t4_full", s_fbr, 0);
        end
        fb_valid = 0;
        chk("t4_accepted", n_acc - acc0, 4);
        for (int k = 0; k < 200 && exp_wr.size() != 0; k++) begin
            lk_idx = 6'(40 + $urandom_range(0, 23));
            cyc();
        end
        lk_valid = 0;
        chk("t4_drained", exp_wr.size(), 0);
        chk("t4_dropped_untouched", mem[24], m24);

        // 5: lookup of the index being updated while the update waits in WR
        reset_dut();
        preload(6'd9, 2'b01);
        push_one(6'd9, 1'b1);
        rd_seen = 0;
        for (int k = 0; k < 10 && !rd_seen; k++) begin
            cyc();
            if (s_en && !s_we && s_addr == 6'd9) rd_seen = 1;
        end
        chk("t5_read", rd_seen, 1);
        cyc();
        lk_valid = 1; lk_idx = 6'd9;
        cyc();
        chk("t5_lk_accept", s_lkr, 1);
        lk_valid = 0;
        cyc();
        chk("t5_rvalid", s_rv, 1);
`ifdef BP_ARB_FWD_EN
        chk("t5_lk_ctr", s_ctr, 2'b10);
`else
        chk("t5_lk_ctr", s_ctr, 2'b01);
`endif
        for (int k = 0; k < 4; k++) cyc();

        // 6: reset while the update is in RWAIT abandons it
        reset_dut();
        preload(6'd11, 2'b10);
        push_one(6'd11, 1'b0);
        rd_seen = 0;
        for (int k = 0; k < 10 && !rd_seen; k++) begin
            cyc();
            if (s_en && !s_we && s_addr == 6'd11) rd_seen = 1;
        end
        chk("t6_read", rd_seen, 1);
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        chk("t6_tbl_en", s_en, 0);
        chk("t6_fb_ready", s_fbr, 1);
        chk("t6_lk_rvalid", s_rv, 0);
        wr_seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (s_en && s_we) wr_seen = 1;
        end
        chk("t6_no_write", wr_seen, 0);
        chk("t6_entry_kept", mem[11], 2'b10);

        // Randomized traffic with occasional resets
        reset_dut();
        for (int k = 0; k < 800; k++) begin
            rst      = ($urandom_range(0, 299) == 0);
            lk_valid = (k < 400) ? 1'($urandom) : ($urandom_range(0, 9) != 0);
            lk_idx   = 6'($urandom_range(0, 7));
            fb_valid = 1'($urandom);
            fb_idx   = 6'($urandom_range(0, 7));
            fb_taken = 1'($urandom);
            cyc();
        end
        rst = 0; lk_valid = 0; fb_valid = 0;
        for (int k = 0; k < 100 && exp_wr.size() != 0; k++) cyc();
        chk("rand_drained", exp_wr.size(), 0);
        mism = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== gold[i]) mism++;
        chk("rand_table", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
